hs4_sender: RTL and testbench

- Parametrised CPU-side sender for the four-phase send/ack handshake to a peripheral on an unrelated clock.
- Buffers words written by the local master in a small FIFO and pushes them out one at a time on dados/send.
- Adds a two-flop ack synchroniser and a per-phase timeout with a sticky error.
- Sits between the CPU core state machine and the peripheral link.

---
 rtl/hs4_pkg.sv | 24 ++
 rtl/hs4_fifo.sv | 70 +++++++
 rtl/hs4_sender.sv | 154 +++++++++++++++
 tb/tb_hs4_sender.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// hs4_pkg: shared definitions for the hs4_sender handshake sender.
//   - default parameter values
//   - 3-bit state encodings (ST_*) and the matching FSM state type
package hs4_pkg;

  localparam int DATA_W_DEF      = 4;
  localparam int DEPTH_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_REL   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_REQ   = ST_REQ,
    S_REL   = ST_REL,
    S_ERR   = ST_ERR
  } state_t;

endpackage

// File: rtl/hs4_fifo.sv
// hs4_fifo: parametrised synchronous FIFO.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset (empties the FIFO)
//   push       - write request, ignored while full
//   push_data  - word to write
//   pop        - read request, ignored while empty
//   head       - word at the read pointer (valid while not empty)
//   full       - count == DEPTH
//   empty      - count == 0
//   count      - words currently stored
module hs4_fifo
  import hs4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  // No bypass: a full FIFO rejects the write even if a pop frees a slot now.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hs4_sender.sv
// hs4_sender: CPU-side sender for a four-phase send/ack handshake.
// Words written on wr_data/wr_valid are buffered in hs4_fifo and pushed out
// one at a time on dados/send. Each ack phase is guarded by a timeout that
// sets a sticky error and discards the word.
// Build option: define HS4_ACK_SYNC_EN to pass ack through a two-flop
// synchroniser (peripheral on an unrelated clock); otherwise ack is used
// directly (peripheral on the same clock).
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-low reset
//   wr_data      - word to send;   wr_valid - write request
//   wr_ready     - FIFO not full
//   dados, send  - registered data / request to the peripheral
//   ack          - peripheral acknowledge
//   err_clr      - clears timeout_err
//   busy         - FIFO non-empty or FSM not idle
//   timeout_err  - sticky timeout flag
//   fifo_count   - words buffered;  estado - current FSM state
module hs4_sender
  import hs4_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] dados,
  output logic              send,
  input  logic              ack,
  input  logic              err_clr,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [2:0]        estado
);

  localparam int            TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit            TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t            state_reg, state_next;
  logic              send_reg;
  logic [DATA_W-1:0] dados_reg;
  logic [TW-1:0]     tcnt_reg;
  logic              timeout_err_reg;
  logic              ack_s;
  logic              pop;
  logic              expire;
  logic              expire_hit;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef HS4_ACK_SYNC_EN
  logic [1:0] ack_sync_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_sync_reg <= 2'b00;
    else      ack_sync_reg <= {ack_sync_reg[0], ack};
  end
  assign ack_s = ack_sync_reg[1];
`else
  assign ack_s = ack;
`endif

  hs4_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign expire = TMO_EN && (tcnt_reg == T_LAST);

  // An ack edge seen in the same cycle as expiry takes priority.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    expire_hit = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A stale ack keeps the word queued until the peripheral releases.
        if (!fifo_empty && !ack_s) begin
          pop        = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: state_next = S_REQ;
      S_REQ: begin
        if (ack_s) begin
          state_next = S_REL;
        end else if (expire) begin
          state_next = S_ERR;
          expire_hit = 1'b1;
        end
      end
      S_REL: begin
        if (!ack_s) begin
          state_next = S_IDLE;
        end else if (expire) begin
          state_next = S_ERR;
          expire_hit = 1'b1;
        end
      end
      S_ERR: begin
        if (!ack_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      send_reg        <= 1'b0;
      dados_reg       <= '0;
      tcnt_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      send_reg  <= (state_next == S_REQ);
      if (pop) dados_reg <= fifo_head;
      // Restart the phase timer on every entry to REQ or REL.
      if ((state_next == S_REQ && state_reg != S_REQ) ||
          (state_next == S_REL && state_reg != S_REL)) begin
        tcnt_reg <= '0;
      end else if (state_reg == S_REQ || state_reg == S_REL) begin
        tcnt_reg <= tcnt_reg + TW'(1);
      end
      // A new expiry beats a simultaneous clear.
      timeout_err_reg <= expire_hit | (timeout_err_reg & ~err_clr);
    end
  end

  assign wr_ready    = ~fifo_full;
  assign dados       = dados_reg;
  assign send        = send_reg;
  assign timeout_err = timeout_err_reg;
  assign estado      = state_reg;
  assign busy        = ~fifo_empty | (state_reg != S_IDLE);

endmodule

// File: tb/tb_hs4_sender.sv
module tb_hs4_sender;

`ifdef HS4_ACK_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] dados;
  logic       send;
  logic       ack;
  logic       err_clr;
  logic       busy;
  logic       timeout_err;
  logic [2:0] fifo_count;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  hs4_sender #(.DATA_W(4), .DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .dados       (dados),
    .send        (send),
    .ack         (ack),
    .err_clr     (err_clr),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fifo_count  (fifo_count),
    .estado      (estado)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic write_word(input logic [3:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_send(input logic level, input int budget);
    int n = 0;
    while (send !== level && n < budget) begin
      step();
      n++;
    end
    chk("wait_send", 32'(send), 32'(level));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || estado !== 3'd0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_busy", 32'(busy), 0);
    chk("idle_estado", 32'(estado), 0);
  endtask

  // Peripheral side of one word: wait for send, check data, ack, release.
  task automatic serve_word(input logic [3:0] exp_d, input int d_ack, input int d_rel);
    wait_send(1'b1, 40);
    chk("serve_dados", 32'(dados), 32'(exp_d));
    repeat (d_ack) step();
    ack = 1'b1;
    wait_send(1'b0, 40);
    repeat (d_rel) step();
    ack = 1'b0;
  endtask

  logic [3:0] exp_q[$];
  logic [3:0] held;
  int         pst, pdly, cyc, n;
  logic       acc, saw_send;

  initial begin
    rst = 1'b0; wr_data = '0; wr_valid = 1'b0; ack = 1'b0; err_clr = 1'b0;
    step(); step();
    chk("rst_send", 32'(send), 0);
    chk("rst_dados", 32'(dados), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_estado", 32'(estado), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    step();

    // Single word: data set up one cycle ahead of send.
    write_word(4'hA);
    chk("t1_count", 32'(fifo_count), 1);
    step();
    chk("t1_setup_estado", 32'(estado), 1);
    chk("t1_setup_dados", 32'(dados), 32'hA);
    chk("t1_setup_send", 32'(send), 0);
    step();
    chk("t1_req_send", 32'(send), 1);
    chk("t1_req_dados", 32'(dados), 32'hA);
    chk("t1_req_estado", 32'(estado), 2);
    repeat (3) step();
    ack = 1'b1;
    n = 0;
    do begin step(); n++; end while (send === 1'b1 && n < 12);
    chk("t1_ack_to_send_fall", 32'(n), 32'(SYNC_LAT + 1));
    chk("t1_rel_estado", 32'(estado), 3);
    chk("t1_rel_dados", 32'(dados), 32'hA);
    step(); step();
    ack = 1'b0;
    repeat (SYNC_LAT + 1) step();
    chk("t1_idle_estado", 32'(estado), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // Burst against a stalled peripheral (ack held high blocks pops).
    ack = 1'b1;
    repeat (SYNC_LAT + 1) step();
    for (int i = 1; i <= 4; i++) begin
      write_word(4'(i));
      chk("t2_count", 32'(fifo_count), 32'(i));
    end
    chk("t2_full_wr_ready", 32'(wr_ready), 0);
    write_word(4'd5);
    chk("t2_drop_count", 32'(fifo_count), 4);
    chk("t2_stall_send", 32'(send), 0);
    chk("t2_stall_estado", 32'(estado), 0);
    ack = 1'b0;
    for (int i = 1; i <= 4; i++) serve_word(4'(i), 1, 1);
    wait_idle(40);
    chk("t2_empty_count", 32'(fifo_count), 0);

    // Stale ack with two words queued.
    ack = 1'b1;
    repeat (SYNC_LAT + 1) step();
    write_word(4'h7);
    write_word(4'h9);
    repeat (5) step();
    chk("t3_stale_count", 32'(fifo_count), 2);
    chk("t3_stale_send", 32'(send), 0);
    chk("t3_stale_estado", 32'(estado), 0);
    ack = 1'b0;
    serve_word(4'h7, 0, 0);
    serve_word(4'h9, 2, 1);
    wait_idle(40);

    // Timeout with no ack: eight cycles of send, then ERR.
    write_word(4'h3);
    wait_send(1'b1, 10);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_send_high", 32'(send), 1);
    end
    step();
    chk("t4_err_estado", 32'(estado), 4);
    chk("t4_err_send", 32'(send), 0);
    chk("t4_err_flag", 32'(timeout_err), 1);
    repeat (3) step();
    chk("t4_back_idle", 32'(estado), 0);
    chk("t4_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_cleared", 32'(timeout_err), 0);

    // err_clr coinciding with a new expiry: the set wins.
    write_word(4'h5);
    wait_send(1'b1, 10);
    repeat (7) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4b_set_wins", 32'(timeout_err), 1);
    chk("t4b_estado", 32'(estado), 4);
    wait_idle(10);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4b_cleared", 32'(timeout_err), 0);

    // ack_s arriving in the expiry cycle: ack wins.
    write_word(4'h6);
    wait_send(1'b1, 10);
    repeat (7 - SYNC_LAT) step();
    ack = 1'b1;
    repeat (SYNC_LAT + 1) step();
    chk("t5_rel_estado", 32'(estado), 3);
    chk("t5_no_err", 32'(timeout_err), 0);
    chk("t5_send_low", 32'(send), 0);
    ack = 1'b0;
    wait_idle(20);

    // Asynchronous reset while in REQ with three words queued.
    write_word(4'h1);
    write_word(4'h2);
    write_word(4'h3);
    write_word(4'h4);
    chk("t6_req_estado", 32'(estado), 2);
    chk("t6_req_count", 32'(fifo_count), 3);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_send", 32'(send), 0);
    chk("t6_rst_count", 32'(fifo_count), 0);
    chk("t6_rst_estado", 32'(estado), 0);
    step();
    rst = 1'b1;
    saw_send = 1'b0;
    repeat (12) begin
      step();
      if (send !== 1'b0) saw_send = 1'b1;
    end
    chk("t6_nothing_sent", 32'(saw_send), 0);
    chk("t6_busy", 32'(busy), 0);

    // Random traffic: every accepted word must appear once, in order.
    pst = 0; pdly = 0; cyc = 0;
    while (cyc < 400 || ((exp_q.size() != 0 || busy !== 1'b0 || pst != 0) && cyc < 800)) begin
      wr_valid = (cyc < 400) && ($urandom_range(0, 1) == 1);
      wr_data  = 4'($urandom_range(0, 15));
      acc = wr_valid && wr_ready;
      if (acc) exp_q.push_back(wr_data);
      step();
      if (pst == 0 && send === 1'b1) begin
        chk("rnd_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("rnd_dados", 32'(dados), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        held = dados;
        pdly = $urandom_range(0, 3);
        pst  = 1;
      end else if (pst == 1 || pst == 2) begin
        chk("rnd_dados_hold", 32'(dados), 32'(held));
      end
      if (pst == 1) begin
        if (pdly == 0) begin ack = 1'b1; pst = 2; end
        else pdly--;
      end else if (pst == 2 && send === 1'b0) begin
        pst  = 3;
        pdly = $urandom_range(0, 3);
      end
      if (pst == 3) begin
        if (pdly == 0) begin ack = 1'b0; pst = 0; end
        else pdly--;
      end
      cyc++;
    end
    wr_valid = 1'b0;
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_busy", 32'(busy), 0);
    chk("rnd_count", 32'(fifo_count), 0);
    chk("rnd_no_err", 32'(timeout_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
